mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_ctrl_pkg.sv | 86 ++++++++
 rtl/mc_controller_if.sv | 33 +++
 rtl/mc_cond_check.sv | 33 +++
 rtl/mc_controller.sv | 93 +++++++++
 tb/tb_mc_controller.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle ARM-subset controller:
// FSM state encoding, instruction class codes, ALU op codes, condition codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Raw Moore control bits for one state, before condition gating.
  typedef struct packed {
    logic       ir_write;
    logic       pc_update;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       reg_w;
    logic       mem_w;
    logic       alu_op;
    logic       branch;
    logic       illegal;
  } ctrl_row_t;

  function automatic ctrl_row_t state_row(input state_t s);
    ctrl_row_t r;
    r = '0;
    case (s)
      FETCH: begin
        r.ir_write = 1'b1; r.pc_update = 1'b1; r.alu_src_a = 1'b1;
        r.alu_src_b = 2'b10; r.result_src = 2'b10;
      end
      DECODE: begin
        r.alu_src_a = 1'b1; r.alu_src_b = 2'b10; r.result_src = 2'b10;
      end
      MEMADR:   r.alu_src_b = 2'b01;
      MEMRD:    r.adr_src = 1'b1;
      MEMWB:    begin r.result_src = 2'b01; r.reg_w = 1'b1; end
      MEMWR:    begin r.adr_src = 1'b1; r.mem_w = 1'b1; end
      EXECUTER: r.alu_op = 1'b1;
      EXECUTEI: begin r.alu_src_b = 2'b01; r.alu_op = 1'b1; end
      ALUWB:    r.reg_w = 1'b1;
      BRANCH:   begin r.alu_src_b = 2'b01; r.result_src = 2'b10; r.branch = 1'b1; end
      UNKNOWN:  r.illegal = 1'b1;
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in, enables/selects out.
// master = datapath side, slave = controller side.
interface mc_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;
  logic       Illegal;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, Illegal
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, Illegal
  );
endinterface

// File: rtl/mc_cond_check.sv
// ARM condition-code evaluation from the stored {N,Z,C,V} flags.
module mc_cond_check
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] flags,
  output logic       CondEx
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM-subset Moore controller. Define ILLEGAL_TRAP_EN to make the
// UNKNOWN state sticky until reset; otherwise UNKNOWN lasts one cycle.
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.slave  bus,
  output state_t          state_dbg
);
  state_t    state, state_nxt;
  ctrl_row_t row;
  logic [3:0] flags;
  logic       cond_ex, cond_ex_reg;
  logic [1:0] alu_control, flag_w;

  mc_cond_check u_cond (
    .Cond   (bus.Cond),
    .flags  (flags),
    .CondEx (cond_ex)
  );

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        case (bus.Op)
          OP_MEM:  state_nxt = MEMADR;
          OP_DP:   state_nxt = bus.Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_nxt = BRANCH;
          default: state_nxt = UNKNOWN;
        endcase
      end
      MEMADR:   state_nxt = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_nxt = MEMWB;
      EXECUTER: state_nxt = ALUWB;
      EXECUTEI: state_nxt = ALUWB;
`ifdef ILLEGAL_TRAP_EN
      UNKNOWN:  state_nxt = UNKNOWN;
`else
      UNKNOWN:  state_nxt = FETCH;
`endif
      default:  state_nxt = FETCH;
    endcase
  end

  // ALU decode is only live while the registered row asserts alu_op.
  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    if (row.alu_op) begin
      case (bus.Funct[4:1])
        4'b0100: begin alu_control = ALU_ADD; flag_w = {2{bus.Funct[0]}}; end
        4'b0010: begin alu_control = ALU_SUB; flag_w = {2{bus.Funct[0]}}; end
        4'b0000: begin alu_control = ALU_AND; flag_w = {bus.Funct[0], 1'b0}; end
        4'b1100: begin alu_control = ALU_ORR; flag_w = {bus.Funct[0], 1'b0}; end
        default: begin alu_control = ALU_ADD; flag_w = 2'b00; end
      endcase
    end
  end

  // Control row is registered from the next state so outputs change with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      row         <= state_row(FETCH);
      cond_ex_reg <= 1'b0;
      flags       <= 4'b0000;
    end else begin
      state <= state_nxt;
      row   <= state_row(state_nxt);
      if (state == DECODE) cond_ex_reg <= cond_ex;
      if (flag_w[1] && cond_ex_reg) flags[3:2] <= bus.ALUFlags[3:2];
      if (flag_w[0] && cond_ex_reg) flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  assign bus.PCWrite    = row.pc_update | (row.branch & cond_ex_reg)
                        | ((state == ALUWB) & (bus.Rd == 4'd15) & cond_ex_reg);
  assign bus.MemWrite   = row.mem_w & cond_ex_reg;
  assign bus.RegWrite   = row.reg_w & cond_ex_reg;
  assign bus.IRWrite    = row.ir_write;
  assign bus.AdrSrc     = row.adr_src;
  assign bus.ALUSrcA    = row.alu_src_a;
  assign bus.ALUSrcB    = row.alu_src_b;
  assign bus.ResultSrc  = row.result_src;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == OP_BR, bus.Op == OP_MEM};
  assign bus.Illegal    = row.illegal;
  assign state_dbg      = state;
endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed instructions plus a random
// instruction stream checked against an instruction-level reference model.
module tb_mc_controller;
  import mc_ctrl_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t state_dbg;
  int     checks = 0;
  int     passes = 0;
  logic [3:0] m_flags = 4'b0000;

  mc_controller_if bus ();

  mc_controller dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ARM condition semantics: pairs of codes share a base test, odd code inverts.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    return c[0] ? !r : r;
  endfunction

  function automatic logic [1:0] exp_alu(input logic [5:0] f);
    case (f[4:1])
      4'b0010: return 2'd1;
      4'b0000: return 2'd2;
      4'b1100: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("rst_state", state_dbg, FETCH);
    check("rst_irwrite", bus.IRWrite, 1'b1);
    check("rst_pcwrite", bus.PCWrite, 1'b1);
    check("rst_regwrite", bus.RegWrite, 1'b0);
    check("rst_memwrite", bus.MemWrite, 1'b0);
    check("rst_illegal", bus.Illegal, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    m_flags = 4'b0000;
  endtask

  // Entered and left at a negedge while the DUT sits in FETCH.
  task automatic run_instr(input string name, input logic [3:0] c, input logic [1:0] op,
                           input logic [5:0] f, input logic [3:0] rd, input logic [3:0] af);
    state_t seq[$];
    state_t st;
    logic   ok;
    bit     is_exec;
    bus.Cond = c; bus.Op = op; bus.Funct = f; bus.Rd = rd; bus.ALUFlags = af;
    ok = cond_holds(c, m_flags);
    seq = '{FETCH, DECODE};
    case (op)
      2'b01: if (f[0]) seq = {seq, MEMADR, MEMRD, MEMWB}; else seq = {seq, MEMADR, MEMWR};
      2'b00: seq = {seq, (f[5] ? EXECUTEI : EXECUTER), ALUWB};
      2'b10: seq.push_back(BRANCH);
      default: seq.push_back(UNKNOWN);
    endcase
    is_exec = (op == 2'b00);
    foreach (seq[i]) begin
      st = seq[i];
      check($sformatf("%s[%0d] state", name, i), state_dbg, st);
      check($sformatf("%s[%0d] regwrite", name, i), bus.RegWrite,
            ok && (st == MEMWB || st == ALUWB));
      check($sformatf("%s[%0d] memwrite", name, i), bus.MemWrite, ok && st == MEMWR);
      check($sformatf("%s[%0d] pcwrite", name, i), bus.PCWrite,
            st == FETCH || (ok && st == BRANCH) || (ok && st == ALUWB && rd == 4'd15));
      check($sformatf("%s[%0d] irwrite", name, i), bus.IRWrite, st == FETCH);
      check($sformatf("%s[%0d] illegal", name, i), bus.Illegal, st == UNKNOWN);
      check($sformatf("%s[%0d] adrsrc", name, i), bus.AdrSrc, st == MEMRD || st == MEMWR);
      check($sformatf("%s[%0d] alusrcb", name, i), bus.ALUSrcB,
            (st == FETCH || st == DECODE) ? 2'b10 :
            (st == MEMADR || st == EXECUTEI || st == BRANCH) ? 2'b01 : 2'b00);
      check($sformatf("%s[%0d] aluctl", name, i), bus.ALUControl,
            (st == EXECUTER || st == EXECUTEI) ? exp_alu(f) : 2'd0);
      check($sformatf("%s[%0d] immsrc", name, i), bus.ImmSrc, op);
      step();
    end
    if (is_exec && ok && f[0]) begin
      case (f[4:1])
        4'b0100, 4'b0010: m_flags = af;
        4'b0000, 4'b1100: m_flags[3:2] = af[3:2];
        default: ;
      endcase
    end
    if (op == 2'b11) begin
`ifdef ILLEGAL_TRAP_EN
      check({name, " trap_state"}, state_dbg, UNKNOWN);
      check({name, " trap_illegal"}, bus.Illegal, 1'b1);
      step();
      check({name, " trap_hold"}, state_dbg, UNKNOWN);
      do_reset();
`else
      check({name, " unk_to_fetch"}, state_dbg, FETCH);
      check({name, " unk_illegal_clr"}, bus.Illegal, 1'b0);
`endif
    end
  endtask

  initial begin
    bus.Cond = COND_AL; bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.ALUFlags = 4'd0;
    repeat (2) @(negedge clk);
    do_reset();
    check("post_rst_state", state_dbg, FETCH);
    check("post_rst_irwrite", bus.IRWrite, 1'b1);
    check("post_rst_pcwrite", bus.PCWrite, 1'b1);

    run_instr("ldr", COND_AL, 2'b01, 6'b011001, 4'd2, 4'($urandom));
    run_instr("subs", COND_AL, 2'b00, 6'b000101, 4'd1, 4'b0100);
    run_instr("beq", COND_EQ, 2'b10, 6'($urandom), 4'($urandom), 4'($urandom));
    run_instr("str_ne", COND_NE, 2'b01, 6'b011000, 4'd3, 4'($urandom));
    run_instr("undef", COND_AL, 2'b11, 6'($urandom), 4'd0, 4'($urandom));
    run_instr("add_pc", COND_AL, 2'b00, 6'b101000, 4'd15, 4'($urandom));
    run_instr("adds_nv", COND_NV, 2'b00, 6'b001001, 4'd15, 4'b1111);

    for (int k = 0; k < 40; k++)
      run_instr($sformatf("rnd%0d", k), 4'($urandom), 2'($urandom_range(0, 3)),
                6'($urandom), 4'($urandom), 4'($urandom));

    // Reset while in EXECUTER must abandon the ADD before its ALUWB write.
    bus.Cond = COND_AL; bus.Op = 2'b00; bus.Funct = 6'b001001; bus.Rd = 4'd4;
    check("mid_fetch", state_dbg, FETCH);
    step();
    check("mid_decode", state_dbg, DECODE);
    step();
    check("mid_execr", state_dbg, EXECUTER);
    reset = 1'b1;
    #1;
    check("mid_async_state", state_dbg, FETCH);
    check("mid_async_pcwrite", bus.PCWrite, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("mid_rst_regwrite%0d", k), bus.RegWrite, 1'b0);
      check($sformatf("mid_rst_state%0d", k), state_dbg, FETCH);
    end
    reset = 1'b0;
    m_flags = 4'b0000;
    check("mid_release_state", state_dbg, FETCH);
    step();
    check("mid_release_decode", state_dbg, DECODE);
    check("mid_release_regwrite", bus.RegWrite, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
